// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD definitions for the word subtractor datapath.
//               Holds the digit width, the largest legal digit value, the
//               controller state encoding and a digit-validity helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  // A nibble is a legal BCD digit when it does not exceed 9.
  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] digit);
    return (digit <= BCD_MAX_DIGIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_word_subtractor_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_word_subtractor_serial_if
// Description : Request/result bundle of the digit-serial BCD subtractor.
// Ports       : start, A, B, Bin      - request (master -> slave)
//               D, Sign, Bout, Err,
//               busy, done            - result/status (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_word_subtractor_serial_if
  import bcd_pkg::*;
#(
  parameter int DIGIT_NUM = 8
);

  logic                           start;
  logic [BCD_DIGIT_W*DIGIT_NUM-1:0] A;
  logic [BCD_DIGIT_W*DIGIT_NUM-1:0] B;
  logic                           Bin;
  logic [BCD_DIGIT_W*DIGIT_NUM-1:0] D;
  logic                           Sign;
  logic                           Bout;
  logic                           Err;
  logic                           busy;
  logic                           done;

  modport master (
    output start, A, B, Bin,
    input  D, Sign, Bout, Err, busy, done
  );

  modport slave (
    input  start, A, B, Bin,
    output D, Sign, Bout, Err, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_sub.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_sub
// Description : Combinational single-digit BCD subtractor, d = a - b - bin
//               with decimal borrow. Inputs are assumed to be legal digits.
// Ports       : a, b  - digit operands
//               bin   - borrow in
//               d     - result digit
//               bout  - borrow out
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   bin,
  output logic [BCD_DIGIT_W-1:0] d,
  output logic                   bout
);

  // One extra bit catches the sign of the raw binary difference (-10..9).
  logic [BCD_DIGIT_W:0] w_diff;

  always_comb begin
    w_diff = {1'b0, a} - {1'b0, b} - {{BCD_DIGIT_W{1'b0}}, bin};
    bout   = w_diff[BCD_DIGIT_W];
    // Negative: low nibble holds t+16, adding 10 modulo 16 yields t+10.
    d      = bout ? (w_diff[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(10))
                  : w_diff[BCD_DIGIT_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/bcd_word_subtractor_serial.sv
`default_nettype none
// ============================================================================
// Module      : bcd_word_subtractor_serial
// Description : Digit-serial packed BCD word subtractor computing
//               A - B - Bin one digit per clock, LSB first. A negative raw
//               difference gets a second serial ten's-complement pass so the
//               result is returned as sign plus magnitude.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-high reset
//               bus   - slave side of bcd_word_subtractor_serial_if
//                       (start/A/B/Bin in, D/Sign/Bout/Err/busy/done out)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_word_subtractor_serial
  import bcd_pkg::*;
#(
  parameter int DIGIT_NUM = 8
)
(
  input  logic clk,
  input  logic rst,
  bcd_word_subtractor_serial_if.slave bus
);

  localparam int c_word_w = BCD_DIGIT_W * DIGIT_NUM;
  localparam int c_idx_w  = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DIGIT_NUM - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [c_word_w-1:0]      r_a;
  logic [c_word_w-1:0]      r_b;
  logic [c_word_w-1:0]      r_d;
  logic [c_idx_w-1:0]       r_idx;
  logic                     r_borrow;
  logic                     r_sign;
  logic                     r_bout;
  logic                     r_err;

  logic [DIGIT_NUM-1:0]     w_digit_ok;
  logic                     w_in_valid;
  logic                     w_last;
  logic [BCD_DIGIT_W-1:0]   w_sub_a;
  logic [BCD_DIGIT_W-1:0]   w_sub_b;
  logic [BCD_DIGIT_W-1:0]   w_sub_d;
  logic                     w_sub_bout;

  // Operand check is done on the bus at the accepting edge, which is exactly
  // the value being latched, so the error decision costs no extra cycle.
  generate
    for (genvar gi = 0; gi < DIGIT_NUM; gi++) begin : g_chk
      assign w_digit_ok[gi] = bcd_digit_valid(bus.A[gi*BCD_DIGIT_W +: BCD_DIGIT_W]) &&
                              bcd_digit_valid(bus.B[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  endgenerate

  assign w_in_valid = &w_digit_ok;
  assign w_last     = (r_idx == c_last_idx);

  // One digit cell serves both passes: SUB takes (a_i, b_i), COMP (0, d_i).
  always_comb begin
    w_sub_a = '0;
    w_sub_b = r_d[int'(r_idx)*BCD_DIGIT_W +: BCD_DIGIT_W];
    if (r_state == SUB) begin
      w_sub_a = r_a[int'(r_idx)*BCD_DIGIT_W +: BCD_DIGIT_W];
      w_sub_b = r_b[int'(r_idx)*BCD_DIGIT_W +: BCD_DIGIT_W];
    end
  end

  bcd_digit_sub u_digit_sub (
    .a    (w_sub_a),
    .b    (w_sub_b),
    .bin  (r_borrow),
    .d    (w_sub_d),
    .bout (w_sub_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (bus.start) w_state_nxt = w_in_valid ? SUB : DONE;
      SUB:  if (w_last)    w_state_nxt = w_sub_bout ? COMP : DONE;
      COMP: if (w_last)    w_state_nxt = DONE;
      DONE:                w_state_nxt = IDLE;
      default:             w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_sign   <= 1'b0;
      r_bout   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_d      <= '0;
            r_idx    <= '0;
            r_sign   <= 1'b0;
            r_bout   <= 1'b0;
            r_err    <= ~w_in_valid;
            r_borrow <= w_in_valid ? bus.Bin : 1'b0;
          end
        end
        SUB: begin
          r_d[int'(r_idx)*BCD_DIGIT_W +: BCD_DIGIT_W] <= w_sub_d;
          if (w_last) begin
            r_bout   <= w_sub_bout;
            r_sign   <= 1'b0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
          end else begin
            r_idx    <= r_idx + 1'b1;
            r_borrow <= w_sub_bout;
          end
        end
        COMP: begin
          r_d[int'(r_idx)*BCD_DIGIT_W +: BCD_DIGIT_W] <= w_sub_d;
          if (w_last) begin
            r_sign   <= 1'b1;
            r_idx    <= '0;
            r_borrow <= 1'b0;
          end else begin
            r_idx    <= r_idx + 1'b1;
            r_borrow <= w_sub_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.D    = r_d;
  assign bus.Sign = r_sign;
  assign bus.Bout = r_bout;
  assign bus.Err  = r_err;
  assign bus.busy = (r_state == SUB) || (r_state == COMP);
  assign bus.done = (r_state == DONE);

endmodule
`default_nettype wire
